// File: rtl/fifo_pkg.sv
// Definitions shared by the sync FIFO and its burst reader: word width and reader FSM encoding.
package fifo_pkg;

  localparam int FIFO_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular skid buffer that absorbs the FIFO read latency and presents a valid/ready stream.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DW       = FIFO_DW,
  parameter int SKID_DEP = 2,
  localparam int PW      = (SKID_DEP > 1) ? $clog2(SKID_DEP) : 1,
  localparam int CW      = $clog2(SKID_DEP) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] cnt
);

  logic [DW-1:0] mem [SKID_DEP];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          acc;

  assign out_valid = (cnt != '0);
  assign acc       = out_valid & out_ready;
  // Storage is not reset; the output is forced to zero whenever nothing is held.
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (acc) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_en, acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops a fixed number of words from the sync FIFO and streams them out with m_last/done.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DW       = FIFO_DW,
  parameter int LEN_W    = 6,
  parameter int SKID_DEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             fifo_rd,
  input  logic [DW-1:0]    fifo_data,
  input  logic             fifo_empty,
  input  logic             fifo_underflow,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             err_uflow
);

  localparam int CW = $clog2(SKID_DEP) + 1;
  localparam logic [CW:0] DEP_C = (CW + 1)'(SKID_DEP);

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] sent;
  logic [CW-1:0]    skid_cnt;
  logic [CW:0]      occ;
  logic             rd_p1;
  logic             accept;
  logic             start_ok;

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign accept   = m_valid & m_ready;
  assign m_last   = m_valid && (sent == len - 1'b1);
  assign start_ok = (state == IDLE) && start;
  // Words held in the skid plus the one still in flight from the FIFO.
  assign occ      = {1'b0, skid_cnt} + {{CW{1'b0}}, rd_p1};

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (burst_len != '0) ? READ : DONE;
        end
      end
      READ: begin
        fifo_rd = !fifo_empty && (issued < len) && (occ < DEP_C);
        if (fifo_rd && (issued == len - 1'b1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && m_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      issued    <= '0;
      sent      <= '0;
      rd_p1     <= 1'b0;
      err_uflow <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_p1 <= fifo_rd;
      if (start_ok) begin
        len       <= burst_len;
        issued    <= '0;
        sent      <= '0;
        err_uflow <= 1'b0;
      end else begin
        if (fifo_rd) begin
          issued <= issued + 1'b1;
        end
        if (accept) begin
          sent <= sent + 1'b1;
        end
        if (busy && fifo_underflow) begin
          err_uflow <= 1'b1;
        end
      end
    end
  end

  // FIFO data_out lands one cycle after the pop, qualified by rd_p1.
  fifo_skid_buf #(
    .DW       (DW),
    .SKID_DEP (SKID_DEP)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (rd_p1),
    .wr_data   (fifo_data),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_ready (m_ready),
    .cnt       (skid_cnt)
  );

endmodule
